// File: rtl/pc_unit.sv
// Fetch PC generator with a circular return-address stack.
// Priority: redirect > stall > RAS pop > sequential increment.
module pc_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned INCR = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          stall_i,
  input  logic                          redirect_i,
  input  logic [DATA_WIDTH-1:0]         redirect_pc_i,
  input  logic                          ras_push_i,
  input  logic                          ras_pop_i,
  output logic [DATA_WIDTH-1:0]         PC_o,
  output logic [DATA_WIDTH-1:0]         PCPlus_o,
  output logic                          misalign_o,
  output logic [$clog2(RAS_DEPTH):0]    ras_count_o,
  output logic                          ras_empty_o
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pc_plus;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         top_q, top_d;
  logic [PW-1:0]         top_inc, top_dec;
  logic                  mis_q, mis_d;
  logic                  push_ok, pop_ok;
  logic [DATA_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [DATA_WIDTH-1:0] ras_d [RAS_DEPTH];

  assign pc_plus = pc_q + DATA_WIDTH'(INCR);
  assign top_inc = top_q + 1'b1;
  assign top_dec = top_q - 1'b1;

  // Push/pop only act on an unstalled, non-redirected cycle; a pop
  // on an empty stack degrades to a sequential fetch.
  assign push_ok = ras_push_i & ~redirect_i & ~stall_i;
  assign pop_ok  = ras_pop_i & ~redirect_i & ~stall_i
                 & (cnt_q != '0);

  // Next-state selection for PC, stack pointer, count and entries.
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    top_d = top_q;
    mis_d = 1'b0;
    ras_d = ras_q;
    if (redirect_i) begin
      pc_d  = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
      mis_d = |redirect_pc_i[1:0];
    end else if (stall_i) begin
      pc_d = pc_q;
    end else if (push_ok && pop_ok) begin
      pc_d         = ras_q[top_q];
      ras_d[top_q] = pc_plus;
    end else if (pop_ok) begin
      pc_d  = ras_q[top_q];
      top_d = top_dec;
      cnt_d = cnt_q - 1'b1;
    end else if (push_ok) begin
      pc_d           = pc_plus;
      ras_d[top_inc] = pc_plus;
      top_d          = top_inc;
      if (cnt_q != DEPTH_C) cnt_d = cnt_q + 1'b1;
    end else begin
      pc_d = pc_plus;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
      top_q <= '0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      top_q <= top_d;
      mis_q <= mis_d;
    end
  end

  // Stack entries need no reset; invalid slots are never read.
  always_ff @(posedge clk_i) begin
    ras_q <= ras_d;
  end

  assign PC_o        = pc_q;
  assign PCPlus_o    = pc_plus;
  assign misalign_o  = mis_q;
  assign ras_count_o = cnt_q;
  assign ras_empty_o = (cnt_q == '0);

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random traffic
// against a queue-based model of the return-address stack.
module tb_pc_unit;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          stall_i;
  logic          redirect_i;
  logic [DW-1:0] redirect_pc_i;
  logic          ras_push_i;
  logic          ras_pop_i;
  logic [DW-1:0] PC_o;
  logic [DW-1:0] PCPlus_o;
  logic          misalign_o;
  logic [CW-1:0] ras_count_o;
  logic          ras_empty_o;

  pc_unit #(
    .DATA_WIDTH  (DW),
    .RESET_VECTOR(32'h0),
    .RAS_DEPTH   (DEPTH),
    .INCR        (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .ras_push_i   (ras_push_i),
    .ras_pop_i    (ras_pop_i),
    .PC_o         (PC_o),
    .PCPlus_o     (PCPlus_o),
    .misalign_o   (misalign_o),
    .ras_count_o  (ras_count_o),
    .ras_empty_o  (ras_empty_o)
  );

  always #5 clk_i = ~clk_i;

  int errs   = 0;
  int checks = 0;

  logic [DW-1:0] m_pc;
  bit            m_mis;
  logic [DW-1:0] m_q[$];

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    logic [DW-1:0] nxt;
    nxt = m_pc + 32'd4;
    chk({tag, ".pc"}, 64'(PC_o), 64'(m_pc));
    chk({tag, ".pcplus"}, 64'(PCPlus_o), 64'(nxt));
    chk({tag, ".cnt"}, 64'(ras_count_o), 64'(m_q.size()));
    chk({tag, ".empty"}, 64'(ras_empty_o),
        64'(m_q.size() == 0));
    chk({tag, ".mis"}, 64'(misalign_o), 64'(m_mis));
  endtask

  task automatic model_reset();
    m_pc  = '0;
    m_mis = 1'b0;
    m_q.delete();
  endtask

  task automatic step(string tag, bit rd, logic [DW-1:0] rpc,
                      bit st, bit pu, bit po);
    logic [DW-1:0] seq;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    stall_i       = st;
    ras_push_i    = pu;
    ras_pop_i     = po;
    @(posedge clk_i);
    seq   = m_pc + 32'd4;
    m_mis = 1'b0;
    if (rd) begin
      m_pc  = rpc & ~32'd3;
      m_mis = (rpc[1:0] != 2'b00);
    end else if (st) begin
      m_pc = m_pc;
    end else if (pu && po && m_q.size() > 0) begin
      m_pc = m_q[m_q.size()-1];
      m_q[m_q.size()-1] = seq;
    end else if (po && m_q.size() > 0) begin
      m_pc = m_q.pop_back();
    end else if (pu) begin
      if (m_q.size() == DEPTH) void'(m_q.pop_front());
      m_q.push_back(seq);
      m_pc = seq;
    end else begin
      m_pc = seq;
    end
    #1;
    chk_all(tag);
  endtask

  task automatic idle_inputs();
    stall_i = 0; redirect_i = 0; redirect_pc_i = '0;
    ras_push_i = 0; ras_pop_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk_all("rst");
    rst_i = 1'b0;
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 3; i++) step("free", 0, 0, 0, 0, 0);
    chk("free.c", 64'(PC_o), 64'h0c);

    step("r35", 1, 32'h10, 0, 0, 0);
    step("s35", 0, 0, 1, 1, 0);
    step("s35", 0, 0, 1, 1, 0);
    chk("stall.pc", 64'(PC_o), 64'h10);
    chk("stall.cnt", 64'(ras_count_o), 64'd0);

    step("r36", 1, 32'h103, 1, 0, 0);
    chk("mis.pc", 64'(PC_o), 64'h100);
    chk("mis.on", 64'(misalign_o), 64'd1);
    step("r36b", 0, 0, 0, 0, 0);
    chk("mis.off", 64'(misalign_o), 64'd0);

    step("r37", 1, 32'h20, 0, 0, 0);
    step("p37", 0, 0, 0, 1, 0);
    step("r37", 1, 32'h40, 0, 0, 0);
    step("p37", 0, 0, 0, 1, 0);
    chk("r37.cnt2", 64'(ras_count_o), 64'd2);
    step("o37", 0, 0, 0, 0, 1);
    chk("r37.ret1", 64'(PC_o), 64'h44);
    step("o37", 0, 0, 0, 0, 1);
    chk("r37.ret2", 64'(PC_o), 64'h24);
    step("o37", 0, 0, 0, 0, 1);
    chk("r37.seq", 64'(PC_o), 64'h28);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      step("r38", 1, 32'(i * 16), 0, 0, 0);
      step("p38", 0, 0, 0, 1, 0);
    end
    chk("r38.sat", 64'(ras_count_o), 64'd4);
    step("o38", 0, 0, 0, 0, 1);
    chk("r38.r0", 64'(PC_o), 64'h44);
    step("o38", 0, 0, 0, 0, 1);
    chk("r38.r1", 64'(PC_o), 64'h34);
    step("o38", 0, 0, 0, 0, 1);
    chk("r38.r2", 64'(PC_o), 64'h24);
    step("o38", 0, 0, 0, 0, 1);
    chk("r38.r3", 64'(PC_o), 64'h14);
    step("o38", 0, 0, 0, 0, 1);
    chk("r38.seq", 64'(PC_o), 64'h18);

    step("r39", 1, 32'h7c, 0, 0, 0);
    step("p39", 0, 0, 0, 1, 0);
    step("r39", 1, 32'h200, 0, 0, 0);
    step("pp39", 0, 0, 0, 1, 1);
    chk("pp.pc", 64'(PC_o), 64'h80);
    chk("pp.cnt", 64'(ras_count_o), 64'd1);
    step("r39", 1, 32'h300, 0, 0, 0);
    step("o39", 0, 0, 0, 0, 1);
    chk("pp.top", 64'(PC_o), 64'h204);

    step("pre", 0, 0, 0, 1, 0);
    redirect_i = 1; redirect_pc_i = 32'h503;
    rst_i = 1'b1;
    model_reset();
    #1;
    chk("arst.pc", 64'(PC_o), 64'h0);
    chk("arst.cnt", 64'(ras_count_o), 64'd0);
    chk("arst.mis", 64'(misalign_o), 64'd0);
    @(posedge clk_i);
    #1;
    chk_all("arst.hold");
    rst_i = 1'b0;
    idle_inputs();
    step("rel", 0, 0, 0, 0, 0);
    chk("rel.pc", 64'(PC_o), 64'h4);

    for (int i = 0; i < 400; i++) begin
      step("rnd",
           $urandom_range(0, 9) == 0,
           $urandom(),
           $urandom_range(0, 6) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
